// File: rtl/quad_step_decoder_pkg.sv
// Shared constants and types for the quadrature step decoder.
// Phase encodings are {A,B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
package quad_step_decoder_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic STEP_UP = 1'b1;
    localparam logic STEP_DN = 1'b0;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_UP,
        EDGE_DN,
        EDGE_BAD
    } edge_e;

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder-side inputs and counter-side step outputs of the quadrature decoder.
// The decoder uses the slave modport; whoever drives the encoder uses master.
interface quad_step_decoder_if;
    logic enable;
    logic a_in;
    logic b_in;
    logic en;
    logic up_d;
    logic err;

    modport master (output enable, a_in, b_in, input en, up_d, err);
    modport slave  (input enable, a_in, b_in, output en, up_d, err);
endinterface

// File: rtl/quad_step_decoder_debounce.sv
// One-bit synchroniser plus debounce: the accepted value only changes after
// DEB_CYCLES consecutive samples that differ from it.
module quad_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   acc_q, acc_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d = '0;
        acc_d = acc_q;
        if (sample != acc_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                acc_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            cnt_q  <= '0;
            acc_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

    assign dout = acc_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: debounced A/B phase tracking that emits a one-cycle step
// strobe with direction, either per valid edge (x4) or per full four-edge cycle (x1).
module quad_step_decoder
    import quad_step_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned X4_MODE     = 0
) (
    input logic                clk,
    input logic                clr,
    quad_step_decoder_if.slave bus
);

    logic              a_acc, b_acc;
    logic [1:0]        phase;
    logic [1:0]        prev_q;
    logic              init_q;
    logic signed [2:0] sub_q, sub_d;
    logic              en_q, en_d;
    logic              up_q, up_d_nx;
    logic              err_q, err_d;
    logic signed [3:0] delta, sum;
    edge_e             kind;

    quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk  (clk),
        .clr  (clr),
        .din  (bus.a_in),
        .dout (a_acc)
    );

    quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk  (clk),
        .clr  (clr),
        .din  (bus.b_in),
        .dout (b_acc)
    );

    assign phase = {a_acc, b_acc};

    always_comb begin
        kind = EDGE_NONE;
        case ({prev_q, phase})
            {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: kind = EDGE_UP;
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: kind = EDGE_DN;
            {PH_00, PH_11}, {PH_11, PH_00}, {PH_10, PH_01}, {PH_01, PH_10}: kind = EDGE_BAD;
            default:                                                        kind = EDGE_NONE;
        endcase
    end

    // Sub-count is widened by one bit so that +4/-4 can be detected before wrapping.
    assign delta = (kind == EDGE_UP) ? 4'sd1 : -4'sd1;
    assign sum   = $signed({sub_q[2], sub_q}) + delta;

    always_comb begin
        sub_d   = sub_q;
        en_d    = 1'b0;
        up_d_nx = up_q;
        err_d   = 1'b0;
        if (!init_q) begin
            if (kind == EDGE_BAD) begin
                err_d = 1'b1;
                sub_d = '0;
            end else if (kind != EDGE_NONE && bus.enable) begin
                if (X4_MODE != 0) begin
                    en_d    = 1'b1;
                    up_d_nx = (kind == EDGE_UP) ? STEP_UP : STEP_DN;
                end else if (sum == 4'sd4) begin
                    en_d    = 1'b1;
                    up_d_nx = STEP_UP;
                    sub_d   = '0;
                end else if (sum == -4'sd4) begin
                    en_d    = 1'b1;
                    up_d_nx = STEP_DN;
                    sub_d   = '0;
                end else begin
                    sub_d = sum[2:0];
                end
            end
        end
        if (!bus.enable) begin
            sub_d = '0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prev_q <= PH_00;
            init_q <= 1'b1;
            sub_q  <= '0;
            en_q   <= 1'b0;
            up_q   <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            prev_q <= phase;
            init_q <= 1'b0;
            sub_q  <= sub_d;
            en_q   <= en_d;
            up_q   <= up_d_nx;
            err_q  <= err_d;
        end
    end

    assign bus.en   = en_q;
    assign bus.up_d = up_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench: one x4 and one x1 decoder share the same encoder stimulus; each
// expected step/err event (kind, direction, cycle) is queued and checked by a monitor.
module tb_quad_step_decoder;

    localparam int K_NONE = 0;
    localparam int K_EN   = 1;
    localparam int K_ERR  = 2;
    localparam int LAT    = 7;

    typedef struct {
        int   kind;
        logic dir;
        int   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    logic a_in, b_in, enable;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    quad_step_decoder_if bus4 ();
    quad_step_decoder_if bus1 ();

    assign bus4.a_in   = a_in;
    assign bus4.b_in   = b_in;
    assign bus4.enable = enable;
    assign bus1.a_in   = a_in;
    assign bus1.b_in   = b_in;
    assign bus1.enable = enable;

    quad_step_decoder #(.SYNC_STAGES(2), .DEB_CYCLES(4), .X4_MODE(1)) dut4 (
        .clk (clk),
        .clr (clr),
        .bus (bus4)
    );

    quad_step_decoder #(.SYNC_STAGES(2), .DEB_CYCLES(4), .X4_MODE(0)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cmp_evt(input string name, input logic en, input logic up,
                           input logic err, input bit have, input exp_t e);
        int kind;
        kind = en ? K_EN : K_ERR;
        n_cmp++;
        if (en && err) begin
            n_bad++;
            $display("FAIL %s: en and err together at cycle %0d", name, cyc);
        end else if (!have) begin
            n_bad++;
            $display("FAIL %s: unexpected kind=%0d up_d=%b at cycle %0d, expected none",
                     name, kind, up, cyc);
        end else if (kind != e.kind || (en && up !== e.dir) || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL %s: got kind=%0d up_d=%b cycle=%0d, expected kind=%0d up_d=%b cycle=%0d",
                     name, kind, up, cyc, e.kind, e.dir, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        e = '{kind: K_NONE, dir: 1'b0, cyc: 0};
        if (!clr) begin
            if (bus4.en || bus4.err) begin
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    cmp_evt("x4_event", bus4.en, bus4.up_d, bus4.err, 1'b1, e);
                end else begin
                    cmp_evt("x4_event", bus4.en, bus4.up_d, bus4.err, 1'b0, e);
                end
            end
            if (bus1.en || bus1.err) begin
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    cmp_evt("x1_event", bus1.en, bus1.up_d, bus1.err, 1'b1, e);
                end else begin
                    cmp_evt("x1_event", bus1.en, bus1.up_d, bus1.err, 1'b0, e);
                end
            end
        end
    end

    task automatic expect_evt(input int k4, input int d4, input int k1, input int d1);
        exp_t e;
        if (k4 != K_NONE) begin
            e.kind = k4;
            e.dir  = d4[0];
            e.cyc  = cyc + LAT;
            q4.push_back(e);
        end
        if (k1 != K_NONE) begin
            e.kind = k1;
            e.dir  = d1[0];
            e.cyc  = cyc + LAT;
            q1.push_back(e);
        end
    endtask

    // Called just after a rising edge; change the phase and hold it.
    task automatic step(input logic a, input logic b, input int k4, input int d4,
                        input int k1, input int d1, input int hold = 10);
        a_in = a;
        b_in = b;
        expect_evt(k4, d4, k1, d1);
        repeat (hold) @(posedge clk);
        #1;
    endtask

    initial begin
        clr    = 1'b1;
        a_in   = 1'b1;
        b_in   = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x4_en", bus4.en, 1'b0);
        chk("rst_x4_up_d", bus4.up_d, 1'b1);
        chk("rst_x4_err", bus4.err, 1'b0);
        chk("rst_x1_en", bus1.en, 1'b0);
        chk("rst_x1_up_d", bus1.up_d, 1'b1);
        chk("rst_x1_err", bus1.err, 1'b0);

        // Release with 11 applied: init captures 00, then both phases settle together.
        clr = 1'b0;
        expect_evt(K_ERR, 0, K_ERR, 0);
        repeat (20) @(posedge clk);
        #1;

        // Move to 00 silently.
        enable = 1'b0;
        step(1'b0, 1'b1, K_NONE, 0, K_NONE, 0);
        step(1'b0, 1'b0, K_NONE, 0, K_NONE, 0);
        enable = 1'b1;

        // Full up cycle.
        step(1'b1, 1'b0, K_EN, 1, K_NONE, 0);
        step(1'b1, 1'b1, K_EN, 1, K_NONE, 0);
        step(1'b0, 1'b1, K_EN, 1, K_NONE, 0);
        step(1'b0, 1'b0, K_EN, 1, K_EN, 1);

        // Full down cycle.
        step(1'b0, 1'b1, K_EN, 0, K_NONE, 0);
        step(1'b1, 1'b1, K_EN, 0, K_NONE, 0);
        step(1'b1, 1'b0, K_EN, 0, K_NONE, 0);
        step(1'b0, 1'b0, K_EN, 0, K_EN, 0);

        // Bounce on A, then settle high.
        for (int i = 0; i < 6; i++) begin
            step(((i % 2) == 0), 1'b0, K_NONE, 0, K_NONE, 0, 2);
        end
        step(1'b1, 1'b0, K_EN, 1, K_NONE, 0);

        enable = 1'b0;
        step(1'b0, 1'b0, K_NONE, 0, K_NONE, 0);
        enable = 1'b1;

        // Illegal jump, then a legal up cycle from 11.
        step(1'b1, 1'b1, K_ERR, 0, K_ERR, 0);
        step(1'b0, 1'b1, K_EN, 1, K_NONE, 0);
        step(1'b0, 1'b0, K_EN, 1, K_NONE, 0);
        step(1'b1, 1'b0, K_EN, 1, K_NONE, 0);
        step(1'b1, 1'b1, K_EN, 1, K_EN, 1);

        // Disabled edges are tracked but dropped from the sub-count.
        enable = 1'b0;
        step(1'b0, 1'b1, K_NONE, 0, K_NONE, 0);
        step(1'b0, 1'b0, K_NONE, 0, K_NONE, 0);
        step(1'b1, 1'b0, K_NONE, 0, K_NONE, 0);
        enable = 1'b1;
        step(1'b1, 1'b1, K_EN, 1, K_NONE, 0);
        step(1'b0, 1'b1, K_EN, 1, K_NONE, 0);
        step(1'b0, 1'b0, K_EN, 1, K_NONE, 0);
        step(1'b1, 1'b0, K_EN, 1, K_EN, 1);
        step(1'b1, 1'b1, K_EN, 1, K_NONE, 0);

        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (q4.size() != 0) begin
            n_bad++;
            $display("FAIL x4_pending: got %0d events outstanding, expected 0", q4.size());
        end
        n_cmp++;
        if (q1.size() != 0) begin
            n_bad++;
            $display("FAIL x1_pending: got %0d events outstanding, expected 0", q1.size());
        end
        chk("end_x4_up_d", bus4.up_d, 1'b1);
        chk("end_x1_up_d", bus1.up_d, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
